data_access_control: RTL and testbench

Data-memory access sequencer for the Aquila RV32IM core, placed between the Execute/Memory stage boundary and the D-side memory port. It issues one load or store per instruction to the data memory or D-cache and aligns load data and byte enables. It generates `stall_for_data_fetch_o`, which feeds the pipeline controller's data-fetch stall input, and it obeys `stall_mem_access_i`, which comes back from that controller.

---
 rtl/aquila_mem_pkg.sv | 28 ++
 rtl/load_aligner.sv | 36 +++
 rtl/data_access_control.sv | 136 +++++++++++++
 tb/tb_data_access_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aquila_mem_pkg.sv
// Shared encodings for the Aquila data-memory access path.
// Size codes, FSM states and byte-enable helper.
package aquila_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } dac_state_t;

  function automatic logic [3:0] be_of(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << off;
      MEM_HALF: be = 4'b0011 << off;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Load-data aligner: picks the addressed byte/half out of the
// read word and sign- or zero-extends it to XLEN.
module load_aligner
  import aquila_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] w_shifted;
  logic            w_sign;

  assign w_shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    data_o = rdata_i;
    case (size_i)
      MEM_BYTE: begin
        w_sign = w_shifted[7] & ~unsigned_i;
        data_o = {{(XLEN-8){w_sign}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        w_sign = w_shifted[15] & ~unsigned_i;
        data_o = {{(XLEN-16){w_sign}}, w_shifted[15:0]};
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_access_control.sv
// Data-memory access sequencer: issues one load/store per
// instruction, aligns load data and stalls the pipeline meanwhile.
module data_access_control
  import aquila_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic            stall_mem_access_i,
  output logic            m_req_o,
  output logic            m_we_o,
  output logic [XLEN-1:0] m_addr_o,
  output logic [3:0]      m_be_o,
  output logic [XLEN-1:0] m_wdata_o,
  input  logic            m_ready_i,
  input  logic [XLEN-1:0] m_rdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            stall_for_data_fetch_o,
  output logic            misaligned_o
);

  dac_state_t      r_state;
  dac_state_t      w_next;
  logic            w_pending;
  logic            w_issue;
  logic            w_done;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_aligned;

  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_off;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [XLEN-1:0] r_rdata;

  always_comb begin
    case (mem_size_i)
      MEM_BYTE: misaligned_o = 1'b0;
      MEM_HALF: misaligned_o = mem_addr_i[0];
      default:  misaligned_o = |mem_addr_i[1:0];
    endcase
  end

  assign w_pending = (mem_re_i | mem_we_i) & ~misaligned_o;
  assign w_issue   = (r_state == S_IDLE) & w_pending
                   & ~stall_mem_access_i;
  assign w_done    = (r_state == S_WAIT) & m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_WAIT;
      S_WAIT:  if (m_ready_i) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset masks pending so the controller never sees a stall during reset.
  always_comb begin
    stall_for_data_fetch_o = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE:  stall_for_data_fetch_o = w_pending;
        S_WAIT:  stall_for_data_fetch_o = 1'b1;
        default: stall_for_data_fetch_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (mem_size_i)
      MEM_BYTE: w_wdata = {(XLEN/8){mem_wdata_i[7:0]}};
      MEM_HALF: w_wdata = {(XLEN/16){mem_wdata_i[15:0]}};
      default:  w_wdata = mem_wdata_i;
    endcase
  end

  load_aligner #(.XLEN(XLEN)) u_align (
    .rdata_i    (m_rdata_i),
    .off_i      (r_off),
    .size_i     (r_size),
    .unsigned_i (r_uns),
    .data_o     (w_aligned)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_rdata <= '0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= mem_we_i;
      r_addr  <= {mem_addr_i[XLEN-1:2], 2'b00};
      r_be    <= be_of(mem_size_i, mem_addr_i[1:0]);
      r_wdata <= w_wdata;
      r_off   <= mem_addr_i[1:0];
      r_size  <= mem_size_i;
      r_uns   <= mem_unsigned_i;
    end else if (w_done) begin
      r_req <= 1'b0;
      if (!r_we) r_rdata <= w_aligned;
    end
  end

  assign m_req_o   = r_req;
  assign m_we_o    = r_we;
  assign m_addr_o  = r_addr;
  assign m_be_o    = r_be;
  assign m_wdata_o = r_wdata;
  assign rdata_o   = r_rdata;

endmodule

// File: tb/tb_data_access_control.sv
// Self-checking bench for data_access_control: directed cases from
// the plan plus randomized accesses against an arithmetic model.
module tb_data_access_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall_mem = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] mrdata = '0;
  logic        req;
  logic        mwe;
  logic [31:0] maddr;
  logic [3:0]  mbe;
  logic [31:0] mwdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mis;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load = '0;

  data_access_control #(.XLEN(32)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .mem_re_i               (re),
    .mem_we_i               (we),
    .mem_size_i             (sz),
    .mem_unsigned_i         (uns),
    .mem_addr_i             (addr),
    .mem_wdata_i            (wdata),
    .stall_mem_access_i     (stall_mem),
    .m_req_o                (req),
    .m_we_o                 (mwe),
    .m_addr_o               (maddr),
    .m_be_o                 (mbe),
    .m_wdata_o              (mwdata),
    .m_ready_i              (ready),
    .m_rdata_i              (mrdata),
    .rdata_o                (rdata),
    .stall_for_data_fetch_o (stall),
    .misaligned_o           (mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w,
    input logic [31:0] a, input int s, input bit u);
    longint unsigned v;
    int sh;
    sh = 8 * int'(a % 4);
    v = longint'(w) >> sh;
    if (s == 0) begin
      v = v % 256;
      if (!u && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (s == 1) begin
      v = v % 65536;
      if (!u && v >= 32768) v = v + 64'hFFFF_0000;
    end else v = longint'(w);
    return v[31:0];
  endfunction

  function automatic logic [3:0] be_model(input logic [31:0] a, input int s);
    int o;
    o = int'(a % 4);
    if (s == 0) return 4'(1 << o);
    if (s == 1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(input logic [31:0] d, input int s);
    if (s == 0) return (d % 256) * 32'h0101_0101;
    if (s == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit mis_model(input logic [31:0] a, input int s);
    if (s == 0) return 1'b0;
    if (s == 1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // Entered and left at posedge+1 with the FSM idle.
  task automatic access(input bit ld, input logic [1:0] s, input bit u,
    input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
    input int k, input int blk);
    re = ld; we = !ld; sz = s; uns = u; addr = a; wdata = d;
    stall_mem = (blk > 0);
    ready = 1'b0;
    for (int j = 0; j < blk; j++) begin
      #1;
      chk("blk_stall", 32'(stall), 32'd1);
      chk("blk_req", 32'(req), 32'd0);
      @(posedge clk); #1;
    end
    stall_mem = 1'b0;
    ready = 1'($urandom % 2);
    #1;
    chk("c0_stall", 32'(stall), 32'd1);
    chk("c0_req", 32'(req), 32'd0);
    chk("c0_mis", 32'(mis), 32'd0);
    for (int i = 1; i <= k; i++) begin
      @(posedge clk); #1;
      ready = (i == k);
      mrdata = (i == k) ? rd : $urandom;
      stall_mem = 1'($urandom % 2);
      #1;
      chk("wait_req", 32'(req), 32'd1);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_addr", maddr, a & 32'hFFFF_FFFC);
      chk("wait_be", 32'(mbe), 32'(be_model(a, int'(s))));
      chk("wait_we", 32'(mwe), 32'(!ld));
      if (!ld) chk("wait_wdata", mwdata, wd_model(d, int'(s)));
    end
    @(posedge clk); #1;
    ready = 1'($urandom % 2);
    mrdata = $urandom;
    #1;
    if (ld) last_load = ld_model(rd, a, int'(s), u);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_req", 32'(req), 32'd0);
    chk("done_rdata", rdata, last_load);
    re = 1'b0; we = 1'b0; stall_mem = 1'b0;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("idle_req", 32'(req), 32'd0);
    chk("hold_rdata", rdata, last_load);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    re = 1'b1;
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(mwe), 32'd0);
    chk("rst_addr", maddr, 32'd0);
    chk("rst_be", 32'(mbe), 32'd0);
    chk("rst_wdata", mwdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    re = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 0);
    chk("word_ld", rdata, 32'hDEAD_BEEF);
    access(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 1, 0);
    chk("sbyte_ld", rdata, 32'hFFFF_FF80);
    access(1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 2, 0);
    chk("ubyte_ld", rdata, 32'h0000_0080);
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD, 32'h0, 1, 0);
    access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0, 32'h9876_0000, 1, 4);

    // Misaligned word load at 0x101 and random misaligned accesses.
    for (int n = 0; n < 12; n++) begin
      if (n == 0) begin
        s = 2'b10; a = 32'h101;
      end else begin
        s = 2'(1 + $urandom % 3);
        a = $urandom;
        if (s == 2'b01) a = a | 32'h1;
        else if (a[1:0] == 2'b00) a = a | 32'($urandom_range(1, 3));
      end
      re = 1'($urandom % 2); we = !re; sz = s; addr = a;
      #1;
      chk("mis_flag", 32'(mis), 32'(mis_model(a, int'(s))));
      chk("mis_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("mis_req", 32'(req), 32'd0);
      chk("mis_stall2", 32'(stall), 32'd0);
      re = 1'b0; we = 1'b0;
    end
    @(posedge clk); #1;

    // Reset while waiting for the memory.
    re = 1'b1; we = 1'b0; sz = 2'b10; addr = 32'h200;
    @(posedge clk); #1;
    chk("rw_req", 32'(req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_req0", 32'(req), 32'd0);
    chk("rw_stall0", 32'(stall), 32'd0);
    re = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    last_load = '0;
    access(1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 32'h1357_9BDF, 2, 0);

    for (int n = 0; n < 40; n++) begin
      s = 2'($urandom % 4);
      a = $urandom;
      if (s == 2'b01) a[0] = 1'b0;
      else if (s != 2'b00) a[1:0] = 2'b00;
      access(1'($urandom % 2), s, 1'($urandom % 2), a, $urandom,
             $urandom, 1 + int'($urandom % 4), int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
